reg_file32_sb: RTL
==================

Name: reg_file32_sb

Overview:
- 8-entry x 32-bit CPU register file with a scoreboard.
- The write side decodes INADDRESS into one-hot register enables, steering one datum into one of N registers. This is the inverse of the operand-select muxes that feed the ALU.
- Two combinational read ports supply operands.
- A per-register busy scoreboard lets decode reserve a destination and stall on operands not yet written back.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 8, number of registers
ADDR_W, 3, address width; NUM_REGS = 2**ADDR_W
CNT_W, 4, width of PENDING; ADDR_W+1

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
IN  input  DATA_W  write-back data
INADDRESS  input  ADDR_W  write destination
WRITEENABLE  input  1  commit IN to INADDRESS at next edge
RESERVE  input  1  mark RSVADDRESS busy at next edge
RSVADDRESS  input  ADDR_W  register to reserve
OUT1ADDRESS  input  ADDR_W  read port 1 address
OUT2ADDRESS  input  ADDR_W  read port 2 address
OUT1  output  DATA_W  contents of OUT1ADDRESS
OUT2  output  DATA_W  contents of OUT2ADDRESS
OUT1BUSY  output  1  busy bit of OUT1ADDRESS
OUT2BUSY  output  1  busy bit of OUT2ADDRESS
PENDING  output  CNT_W  number of busy registers

Behaviour:
- One clock CLK. Reset is synchronous and active-high (RESET). All state changes on the CLK rising edge only.
- Reset, when RESET=1 at an edge:
  - all registers become 0 and all busy bits become 0, so PENDING=0;
  - RESET overrides WRITEENABLE/RESERVE in the same cycle;
  - asserting reset mid-sequence discards all outstanding reservations.
- Read ports:
  - purely combinational from current state;
  - OUT1/OUT2 and OUT1BUSY/OUT2BUSY change in the same cycle the address changes;
  - no write bypass: a read of the register being written shows the old value until the edge, the new value after it.
- Write, when WRITEENABLE=1 at an edge:
  - reg[INADDRESS] <= IN, latency 1 edge;
  - busy[INADDRESS] cleared;
  - a write to a non-busy register is legal: data is stored and busy stays 0.
- Reserve, when RESERVE=1 at an edge:
  - busy[RSVADDRESS] <= 1;
  - reserving an already-busy register is idempotent: busy stays 1 and PENDING is unchanged.
- Write and reserve to the same address in the same cycle: data written, then the new reservation wins, so busy=1 after the edge. PENDING nets accordingly: unchanged if the register was busy, +1 if it was not.
- Write and reserve to different addresses in the same cycle: both take effect. PENDING = previous - (write cleared a busy bit) + (reserve set a new bit).
- PENDING:
  - a registered popcount of the busy vector, kept consistent with busy after every edge;
  - range 0..NUM_REGS, with no wrap because CNT_W = ADDR_W+1.
- Outputs never X after the first reset edge. Before the first reset, state is undefined.
- No register is hardwired to zero.

Decomposition:
- Shared package cpu_pkg holds:
  - constants DATA_W=32, ADDR_W=3, NUM_REGS=8;
  - typedef reg_addr_t (ADDR_W bits) and data_t (DATA_W bits).
  - The operand muxes and ALU reuse these.
- One sub-module: dec_onehot (ADDR_W -> NUM_REGS one-hot decoder with enable). It is instantiated twice: the write decoder (enable WRITEENABLE) and the reserve decoder (enable RESERVE).
- The busy update is then busy_next = (busy & ~wr_oh) | rsv_oh.

Test Plan:
- Reset: hold RESET for 2 edges with WRITEENABLE=1, IN=32'hFFFFFFFF -> all reads return 0, all BUSY=0, PENDING=0.
- Write/read: write 32'h0000_00A5 to r3 and 32'hDEAD_BEEF to r7; set OUT1ADDRESS=3, OUT2ADDRESS=7.
  - Before the edge: old value (0).
  - After the edge: OUT1=32'h0000_00A5, OUT2=32'hDEAD_BEEF, same cycle as the address change.
- Scoreboard: reserve r2, then r5, then r2 again -> PENDING=1,2,2. Write r2=32'h11 -> OUT1BUSY(addr 2)=0, PENDING=1, OUT1=32'h11.
- Same-address collision: r4 busy; in one cycle WRITEENABLE and RESERVE both target r4 with IN=32'h44 -> reg[4]=32'h44, busy[4]=1, PENDING unchanged.
- Different-address collision: r1 busy; write r1 and reserve r6 in one cycle -> busy[1]=0, busy[6]=1, PENDING unchanged.
- Fill and mid-op reset:
  - reserve all 8 registers -> PENDING=8;
  - assert RESET with WRITEENABLE=1 to r0 -> next edge PENDING=0 and r0=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions. The register file, operand muxes and ALU
// use these widths and types.
//   DATA_W   : register / operand width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   CNT_W    : width of a 0..NUM_REGS count (one bit wider than ADDR_W)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Number of set bits in a register-wide mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// -----------------------------------------------------------------------------
// dec_onehot
// Binary-to-one-hot decoder with enable. With i_en low the output is all
// zeros; with i_en high exactly bit i_addr is set.
//   i_en     : decode enable
//   i_addr   : binary register address
//   o_onehot : one-hot register select
// -----------------------------------------------------------------------------
module dec_onehot
  import cpu_pkg::*;
#(
  parameter int A_W   = ADDR_W,
  parameter int N_OUT = NUM_REGS
) (
  input  logic             i_en,
  input  logic [A_W-1:0]   i_addr,
  output logic [N_OUT-1:0] o_onehot
);

  always_comb begin
    // NOTE: assigning a default before the conditional keeps this block
    // purely combinational; without it the enable-low path would infer a latch.
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file32_sb.sv
// -----------------------------------------------------------------------------
// reg_file32_sb
// 8 x 32-bit CPU register file with a per-register busy scoreboard.
//   CLK          : rising-edge clock
//   RESET        : synchronous active-high reset (clears data, busy, PENDING)
//   IN           : write-back data
//   INADDRESS    : write destination
//   WRITEENABLE  : commit IN to INADDRESS and clear its busy bit
//   RESERVE      : mark RSVADDRESS busy
//   RSVADDRESS   : register to reserve
//   OUT1ADDRESS  : read port 1 address
//   OUT2ADDRESS  : read port 2 address
//   OUT1 / OUT2  : combinational read data (no write bypass)
//   OUT1BUSY / OUT2BUSY : busy bits of the read addresses
//   PENDING      : registered count of busy registers
// -----------------------------------------------------------------------------
module reg_file32_sb
  import cpu_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  data_t            IN,
  input  reg_addr_t        INADDRESS,
  input  logic             WRITEENABLE,
  input  logic             RESERVE,
  input  reg_addr_t        RSVADDRESS,
  input  reg_addr_t        OUT1ADDRESS,
  input  reg_addr_t        OUT2ADDRESS,
  output data_t            OUT1,
  output data_t            OUT2,
  output logic             OUT1BUSY,
  output logic             OUT2BUSY,
  output logic [CNT_W-1:0] PENDING
);

  logic [NUM_REGS-1:0] w_wr_oh;
  logic [NUM_REGS-1:0] w_rsv_oh;
  logic [NUM_REGS-1:0] w_busy_next;

  data_t               r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_pending;

  dec_onehot u_wr_dec (
    .i_en     (WRITEENABLE),
    .i_addr   (INADDRESS),
    .o_onehot (w_wr_oh)
  );

  dec_onehot u_rsv_dec (
    .i_en     (RESERVE),
    .i_addr   (RSVADDRESS),
    .o_onehot (w_rsv_oh)
  );

  // Write-back releases its register; a same-cycle reservation is applied
  // afterwards so it wins on an address collision.
  assign w_busy_next = (r_busy & ~w_wr_oh) | w_rsv_oh;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the register array is reset explicitly because reads must return
      // zero after reset; a plain storage array would normally be left unreset.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples
      // pre-edge values, independent of statement order.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_oh[i]) begin
          r_regs[i] <= IN;
        end
      end
      r_busy    <= w_busy_next;
      // Counting the next busy vector keeps PENDING aligned with busy.
      r_pending <= popcount(w_busy_next);
    end
  end

  assign OUT1     = r_regs[OUT1ADDRESS];
  assign OUT2     = r_regs[OUT2ADDRESS];
  assign OUT1BUSY = r_busy[OUT1ADDRESS];
  assign OUT2BUSY = r_busy[OUT2ADDRESS];
  assign PENDING  = r_pending;

endmodule
